// File: rtl/text_write_scheduler_pkg.sv
// Shared types and helpers for the text-overlay write scheduler.
// Holds FSM states, default sizes and the wrap-around index helper.
package text_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_CHAR_W  = 8;
  localparam int DEF_MAX_LEN = 32;

  // base and off are both below n, so one subtraction wraps
  function automatic int wrap_idx(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/text_write_scheduler_if.sv
// Requester/buffer bundle of the text write scheduler.
// master = requesters and char RAM side, slave = scheduler.
interface text_write_scheduler_if
  import text_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) ();

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);

  logic [NUM_REQ-1:0]             i_req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_base;
  logic [NUM_REQ-1:0][LEN_W-1:0]  i_req_len;
  logic [NUM_REQ-1:0][CHAR_W-1:0] i_char;
  logic                           i_vblank;
  logic [NUM_REQ-1:0]             o_grant;
  logic [IDX_W-1:0]               o_char_idx;
  logic                           o_wr_en;
  logic [ADDR_W-1:0]              o_wr_addr;
  logic [CHAR_W-1:0]              o_wr_data;
  logic [NUM_REQ-1:0]             o_done;
  logic                           o_busy;

  modport master (
    output i_req, i_req_base, i_req_len,
    output i_char, i_vblank,
    input  o_grant, o_char_idx, o_wr_en,
    input  o_wr_addr, o_wr_data,
    input  o_done, o_busy
  );

  modport slave (
    input  i_req, i_req_base, i_req_len,
    input  i_char, i_vblank,
    output o_grant, o_char_idx, o_wr_en,
    output o_wr_addr, o_wr_data,
    output o_done, o_busy
  );

endinterface

// File: rtl/text_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request
// at or after ptr, wrapping modulo NUM_REQ.
module rr_arbiter
  import text_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               vld
);

  logic [PTR_W-1:0] k;

  // scan farthest-first so the nearest hit wins
  always_comb begin
    idx = '0;
    vld = 1'b0;
    k   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = PTR_W'(wrap_idx(int'(ptr), i, NUM_REQ));
      if (req[k]) begin
        idx = k;
        vld = 1'b1;
      end
    end
    gnt = vld ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/text_write_scheduler.sv
// Round-robin owner of the character-buffer write port;
// streams one granted string per burst, gated to vblank.
module text_write_scheduler
  import text_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input logic i_clk,
  input logic i_rst_n,
  text_write_scheduler_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int PTR_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [CHAR_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [LEN_W-1:0]   len_in;
  logic [LEN_W-1:0]   len_sat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (bus.i_req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .vld (arb_vld)
  );

  assign len_in  = bus.i_req_len[arb_idx];
  assign len_sat = (len_in > LEN_W'(MAX_LEN))
                 ? LEN_W'(MAX_LEN) : len_in;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    done_d    = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gidx_d  = arb_idx;
          base_d  = bus.i_req_base[arb_idx];
          len_d   = len_sat;
          idx_d   = '0;
          grant_d = arb_gnt;
          state_d = (len_sat == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        // without vblank nothing moves; idx holds the resume point
        if (bus.i_vblank) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_W'(idx_q);
          wr_data_d = bus.i_char[gidx_q];
          if (LEN_W'(idx_q) == len_q - LEN_W'(1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        done_d   = grant_q;
        grant_d  = '0;
        rr_ptr_d = PTR_W'(wrap_idx(int'(gidx_q), 1, NUM_REQ));
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.o_grant    = grant_q;
  assign bus.o_char_idx = idx_q;
  assign bus.o_wr_en    = wr_en_q;
  assign bus.o_wr_addr  = wr_addr_q;
  assign bus.o_wr_data  = wr_data_q;
  assign bus.o_done     = done_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_text_write_scheduler.sv
// Directed bench for text_write_scheduler: bursts, round
// robin order, vblank gaps, wrap, zero length, reset abort.
module tb_text_write_scheduler;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int ML = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   t0;

  logic [7:0]    txt [NR][ML];
  logic [AW-1:0] wa [$];
  logic [CW-1:0] wd [$];
  int            wc [$];
  logic [NR-1:0] dv [$];
  int            dc [$];
  logic [NR-1:0] gv [$];
  int            gc [$];
  logic          gprev = 1'b0;

  logic [3:0] ord [4];
  int         ri  [4];
  logic [7:0] wrap_a [4];

  text_write_scheduler_if #(
    .NUM_REQ (NR), .ADDR_W (AW),
    .CHAR_W (CW), .MAX_LEN (ML)
  ) bus ();

  text_write_scheduler #(
    .NUM_REQ (NR), .ADDR_W (AW),
    .CHAR_W (CW), .MAX_LEN (ML)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int r = 0; r < NR; r++)
      bus.i_char[r] = txt[r][bus.o_char_idx];
  end

  always @(negedge clk) begin
    if (bus.o_wr_en) begin
      wa.push_back(bus.o_wr_addr);
      wd.push_back(bus.o_wr_data);
      wc.push_back(cyc);
    end
    if (|bus.o_done) begin
      dv.push_back(bus.o_done);
      dc.push_back(cyc);
    end
    if (|bus.o_grant && !gprev) begin
      gv.push_back(bus.o_grant);
      gc.push_back(cyc);
    end
    gprev <= |bus.o_grant;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete();
    dv.delete(); dc.delete();
    gv.delete(); gc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req = '0;
    bus.i_vblank = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
  endtask

  task automatic grab();
    int t = 0;
    while (gv.size() == 0 && t < 10) begin
      tick();
      t++;
    end
    check("grant_seen", gv.size() != 0, 1);
    bus.i_req = '0;
  endtask

  task automatic wait_wr(input int n, input int max);
    int t = 0;
    while (wa.size() < n && t < max) begin
      tick();
      t++;
    end
    check("wr_seen", wa.size() >= n, 1);
  endtask

  task automatic wait_dones(input int n, input int max);
    int t = 0;
    while (dv.size() < n && t < max) begin
      tick();
      t++;
    end
    check("done_cnt", dv.size(), n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant"}, bus.o_grant, 0);
    check({tag, "_we"}, bus.o_wr_en, 0);
    check({tag, "_addr"}, bus.o_wr_addr, 0);
    check({tag, "_data"}, bus.o_wr_data, 0);
    check({tag, "_done"}, bus.o_done, 0);
    check({tag, "_idx"}, bus.o_char_idx, 0);
    check({tag, "_busy"}, bus.o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < NR; r++)
      for (int i = 0; i < ML; i++)
        txt[r][i] = 8'(r * 40 + i + 1);
    bus.i_req      = '0;
    bus.i_req_base = '0;
    bus.i_req_len  = '0;
    bus.i_vblank   = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    check_zero("rst");
    rst_n = 1'b1;
    clr();

    // basic 3-char burst
    txt[0][0] = 8'h48;
    txt[0][1] = 8'h65;
    txt[0][2] = 8'h6c;
    bus.i_req_base[0] = 8'h10;
    bus.i_req_len[0]  = 6'd3;
    t0 = cyc;
    bus.i_req = 4'b0001;
    grab();
    wait_dones(1, 20);
    check("t1_lat", gc[0], t0 + 1);
    check("t1_n", wa.size(), 3);
    check("t1_a0", wa[0], 8'h10);
    check("t1_d0", wd[0], 8'h48);
    check("t1_a1", wa[1], 8'h11);
    check("t1_d1", wd[1], 8'h65);
    check("t1_a2", wa[2], 8'h12);
    check("t1_d2", wd[2], 8'h6c);
    check("t1_c0", wc[0], t0 + 2);
    check("t1_cont", wc[2] - wc[0], 2);
    check("t1_dcyc", dc[0], wc[2] + 1);
    check("t1_done", dv[0], 4'b0001);
    check("t1_busy", bus.o_busy, 0);
    check("t1_gclr", bus.o_grant, 0);
    txt[0][0] = 8'd1;
    txt[0][1] = 8'd2;
    txt[0][2] = 8'd3;

    // round robin over 1011
    do_reset();
    for (int r = 0; r < NR; r++) begin
      bus.i_req_base[r] = 8'(8'h20 + r * 16);
      bus.i_req_len[r]  = 6'd2;
    end
    ord = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    ri  = '{0, 1, 3, 0};
    bus.i_req = 4'b1011;
    wait_dones(4, 60);
    bus.i_req = '0;
    repeat (4) tick();
    check("t2_ng", gv.size(), 4);
    check("t2_nd", dv.size(), 4);
    check("t2_nw", wa.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_g%0d", i), gv[i], ord[i]);
      check($sformatf("t2_dn%0d", i), dv[i], ord[i]);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_a%0d", i), wa[i],
            8'(8'h20 + ri[i/2] * 16 + i % 2));
      check($sformatf("t2_d%0d", i), wd[i],
            txt[ri[i/2]][i % 2]);
    end

    // vblank gap after 2nd write
    do_reset();
    bus.i_req_base[0] = 8'h60;
    bus.i_req_len[0]  = 6'd5;
    bus.i_req = 4'b0001;
    grab();
    wait_wr(2, 20);
    bus.i_vblank = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("t3_gap_we", bus.o_wr_en, 0);
      check("t3_gap_idx", bus.o_char_idx, 2);
    end
    bus.i_vblank = 1'b1;
    wait_dones(1, 20);
    check("t3_n", wa.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_a%0d", i), wa[i], 8'(8'h60 + i));
      check($sformatf("t3_d%0d", i), wd[i], txt[0][i]);
    end
    check("t3_gap", wc[2] - wc[1], 8);
    check("t3_tail", wc[4] - wc[2], 2);

    // address wrap
    do_reset();
    bus.i_req_base[1] = 8'hFE;
    bus.i_req_len[1]  = 6'd4;
    bus.i_req = 4'b0010;
    grab();
    wait_dones(1, 20);
    wrap_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check("t4_n", wa.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_a%0d", i), wa[i], wrap_a[i]);
    check("t4_done", dv[0], 4'b0010);

    // zero length then next requester
    do_reset();
    bus.i_req_base[2] = 8'h70;
    bus.i_req_len[2]  = 6'd0;
    bus.i_req_base[3] = 8'h80;
    bus.i_req_len[3]  = 6'd1;
    bus.i_req = 4'b1100;
    wait_dones(2, 30);
    bus.i_req = '0;
    repeat (3) tick();
    check("t5_g0", gv[0], 4'b0100);
    check("t5_d0", dv[0], 4'b0100);
    check("t5_glen", dc[0] - gc[0], 1);
    check("t5_g1", gv[1], 4'b1000);
    check("t5_d1", dv[1], 4'b1000);
    check("t5_next", gc[1], dc[0] + 1);
    check("t5_nw", wa.size(), 1);
    check("t5_a", wa[0], 8'h80);
    check("t5_wc", wc[0], gc[1] + 1);

    // reset mid-burst
    do_reset();
    bus.i_req_base[0] = 8'h90;
    bus.i_req_len[0]  = 6'd1;
    bus.i_req = 4'b0001;
    grab();
    wait_dones(1, 20);
    clr();
    bus.i_req_base[1] = 8'hA0;
    bus.i_req_len[1]  = 6'd8;
    bus.i_req = 4'b0010;
    grab();
    wait_wr(2, 20);
    rst_n = 1'b0;
    bus.i_req = 4'b0011;
    tick();
    check_zero("t6_rst");
    tick();
    rst_n = 1'b1;
    check("t6_nw", wa.size(), 2);
    check("t6_nd", dv.size(), 0);
    clr();
    grab();
    check("t6_first", gv[0], 4'b0001);
    wait_dones(1, 20);
    check("t6_done", dv[0], 4'b0001);
    check("t6_a", wa[0], 8'h90);

    // length saturation
    do_reset();
    bus.i_req_base[2] = 8'h00;
    bus.i_req_len[2]  = 6'd40;
    bus.i_req = 4'b0100;
    grab();
    wait_dones(1, 60);
    check("t7_n", wa.size(), 32);
    check("t7_alast", wa[31], 8'h1F);
    check("t7_dlast", wd[31], txt[2][31]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
